// File: rtl/addsub_pkg.sv
// addsub_pkg: opcodes, EX flag indices and operand helpers shared by the add/sub pipeline
package addsub_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADC = 2'b10, OP_SBC = 2'b11} op_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  function automatic logic inv_b(logic [1:0] op);
    return op[0];
  endfunction
  function automatic logic init_carry(logic [1:0] op, logic cin);
    return op[1] ? cin : op[0];
  endfunction
endpackage

// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: operand and result handshake bundle of the add/sub pipeline
interface addsub_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  modport master (
    output in_valid, op, operand_a, operand_b, carry_in, out_ready,
    input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
  );
  modport slave (
    input  in_valid, op, operand_a, operand_b, carry_in, out_ready,
    output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/addsub_segment.sv
// addsub_segment: combinational SEG-bit adder slice with carry out and zero detect
module addsub_segment #(parameter int SEG = 8) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b_eff,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           seg_zero
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{SEG{1'b0}}, cin};
  assign seg_zero = ~|sum;
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: segmented pipelined ADD/SUB/ADC/SBC with NZCV flags and full backpressure
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input logic        clock,
  input logic        reset,
  addsub_pipe_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  localparam logic [STAGES-1:0] ONES = '1;
  logic [STAGES-1:0] valid_q, c_q, z_q, load;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [WIDTH-1:0]  a_s [STAGES];
  logic [WIDTH-1:0]  b_s [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [WIDTH-1:0]  r_d [STAGES];
  logic [SEG-1:0]    sum [STAGES];
  logic [STAGES-1:0] c_s, z_s, v_s, co, sz;
  logic [3:0]        flags;
  always_comb begin
    a_s[0] = bus.operand_a;
    b_s[0] = bus.operand_b ^ {WIDTH{inv_b(bus.op)}};
    r_s[0] = '0;
    c_s[0] = init_carry(bus.op, bus.carry_in);
    z_s[0] = 1'b1;
    v_s[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_s[k] = a_q[k-1];
      b_s[k] = b_q[k-1];
      r_s[k] = r_q[k-1];
      c_s[k] = c_q[k-1];
      z_s[k] = z_q[k-1];
      v_s[k] = valid_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r_d[k] = r_s[k];
      r_d[k][k*SEG +: SEG] = sum[k];
    end
  end
  // A stage can load unless it and every stage after it are full and the consumer stalls
  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    addsub_segment #(.SEG(SEG)) u_seg (
      .a(a_s[k][k*SEG +: SEG]),
      .b_eff(b_s[k][k*SEG +: SEG]),
      .cin(c_s[k]),
      .sum(sum[k]),
      .cout(co[k]),
      .seg_zero(sz[k])
    );
    assign load[k] = bus.out_ready || ((valid_q >> k) != (ONES >> k));
  end
  always_ff @(posedge clock)
    if (reset) begin
      valid_q <= '0;
      c_q <= '0;
      z_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) valid_q[k] <= v_s[k];
        if (load[k] && v_s[k]) begin
          a_q[k] <= a_s[k];
          b_q[k] <= b_s[k];
          r_q[k] <= r_d[k];
          c_q[k] <= co[k];
          z_q[k] <= z_s[k] & sz[k];
        end
      end
  always_comb begin
    flags = '0;
    flags[FLAG_N] = r_q[L][WIDTH-1];
    flags[FLAG_Z] = z_q[L];
    flags[FLAG_C] = c_q[L];
    flags[FLAG_V] = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) && (r_q[L][WIDTH-1] != a_q[L][WIDTH-1]);
  end
  assign bus.in_ready  = load[0];
  assign bus.out_valid = valid_q[L];
  assign bus.result    = r_q[L];
  assign bus.flag_n    = flags[FLAG_N];
  assign bus.flag_z    = flags[FLAG_Z];
  assign bus.flag_c    = flags[FLAG_C];
  assign bus.flag_v    = flags[FLAG_V];
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed and randomized checks of addsub_pipe against an arithmetic reference model
module tb_addsub_pipe;
  import addsub_pkg::*;
  localparam int W = 16;
  localparam int S = 2;
  localparam longint SMAX = (64'sd1 <<< (W - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (W - 1));
  typedef struct packed {
    logic [W-1:0] r;
    logic n, z, c, v;
  } res_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  res_t exp_q[$];
  res_t e;
  logic acc;
  addsub_pipe_if #(.WIDTH(W)) bus ();
  addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  function automatic res_t model(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b, logic cin);
    logic [W-1:0] be;
    longint c0, u, s;
    res_t m;
    be = (o == OP_SUB || o == OP_SBC) ? ~b : b;
    c0 = (o == OP_ADD) ? 0 : (o == OP_SUB) ? 1 : longint'(cin);
    u = longint'(a) + longint'(be) + c0;
    s = longint'($signed(a)) + longint'($signed(be)) + c0;
    m.r = u[W-1:0];
    m.n = m.r[W-1];
    m.z = (m.r == '0);
    m.c = (u >= (64'sd1 <<< W));
    m.v = (s > SMAX) || (s < SMIN);
    return m;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.carry_in = c;
  endtask
  task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    drive(o, a, b, c);
    @(negedge clock);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (!bus.in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic expect_out(input string tag, input logic [W-1:0] r, input logic [3:0] f);
    int n = 0;
    @(negedge clock);
    while (!(bus.out_valid && bus.out_ready) && n < 20) begin
      n++;
      @(negedge clock);
    end
    chk({tag, "_valid"}, 32'(bus.out_valid && bus.out_ready), 32'd1);
    chk({tag, "_res"}, 32'(bus.result), 32'(r));
    chk({tag, "_flags"}, 32'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 32'(f));
    @(posedge clock);
    #1;
  endtask
  // Scoreboard: every accepted operand set must retire once, in order, with model values
  always @(negedge clock) begin
    if (reset) exp_q.delete();
    else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("scoreboard", 32'({bus.result, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 32'(e));
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.op, bus.operand_a, bus.operand_b, bus.carry_in));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.op = OP_ADD;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.carry_in = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags", 32'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;
    send(OP_ADD, 16'h0001, 16'h0003, 1'b0);
    @(negedge clock);
    chk("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    chk("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
    chk("add_res", 32'(bus.result), 32'h0004);
    chk("add_flags", 32'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 32'b0000);
    @(posedge clock);
    #1;
    send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    expect_out("add_wrap", 16'h0000, 4'b0110);
    send(OP_SUB, 16'h7FFF, 16'hFFFF, 1'b0);
    expect_out("sub_ovf", 16'h8000, 4'b1001);
    send(OP_ADC, 16'h00FF, 16'h0001, 1'b1);
    expect_out("adc", 16'h0101, 4'b0000);
    send(OP_SBC, 16'h0005, 16'h0003, 1'b1);
    expect_out("sbc", 16'h0002, 4'b0010);
    bus.out_ready = 1'b0;
    drive(OP_ADD, 16'd1, 16'd1, 1'b0);
    @(posedge clock);
    #1 drive(OP_ADD, 16'd2, 16'd2, 1'b0);
    @(posedge clock);
    #1 drive(OP_ADD, 16'd3, 16'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      chk("bp_valid_hold", 32'(bus.out_valid), 32'd1);
      chk("bp_result_hold", 32'(bus.result), 32'h0002);
      @(posedge clock);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    chk("bp_r0", 32'(bus.result), 32'h0002);
    @(posedge clock);
    #1 drive(OP_ADD, 16'd4, 16'd4, 1'b0);
    @(negedge clock);
    chk("bp_r1", 32'(bus.result), 32'h0004);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    @(negedge clock);
    chk("bp_r2", 32'(bus.result), 32'h0006);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("bp_r3", 32'(bus.result), 32'h0008);
    chk("bp_r3_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_hold", 32'(bus.result), 32'h0008);
    @(posedge clock);
    #1 bus.out_ready = 1'b0;
    drive(OP_ADD, 16'd5, 16'd5, 1'b0);
    @(posedge clock);
    #1 drive(OP_ADD, 16'd6, 16'd6, 1'b0);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_result", 32'(bus.result), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_no_stale", 32'(bus.out_valid), 32'd0);
      @(posedge clock);
      #1;
    end
    send(OP_ADD, 16'h0010, 16'h0020, 1'b0);
    expect_out("post_rst", 16'h0030, 4'b0000);
    acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.op = 2'($urandom_range(0, 3));
        bus.operand_a = W'($urandom);
        bus.operand_b = W'($urandom);
        bus.carry_in = 1'($urandom_range(0, 1));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
    @(negedge clock);
    chk("random_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
